// File: rtl/mac_accumulator_if.sv
// Streaming interface between the arithmetic front end, the frame
// accumulator and the downstream consumer of frame results.
interface mac_accumulator_if #(
   parameter int N     = 4,
   parameter int ACC_W = 12,
   parameter int CNT_W = 5
);
   logic               clear;
   logic               in_valid;
   logic               in_ready;
   logic [N:0]         sum_in;
   logic [2*N-1:0]     prod_in;
   logic               out_valid;
   logic               out_ready;
   logic [ACC_W-1:0]   acc_sum;
   logic [ACC_W-1:0]   acc_prod;
   logic               ovf;
   logic [CNT_W-1:0]   beat_cnt;

   // Producer of beats / consumer of results
   modport master (
      output clear, in_valid, sum_in, prod_in, out_ready,
      input  in_ready, out_valid, acc_sum, acc_prod, ovf, beat_cnt
   );

   // The accumulator itself
   modport slave (
      input  clear, in_valid, sum_in, prod_in, out_ready,
      output in_ready, out_valid, acc_sum, acc_prod, ovf, beat_cnt
   );
endinterface

// File: rtl/mac_accumulator.sv
// Frame accumulator: sums K beats of {cout,sum} and prod into two running
// totals, then presents the frame result on a valid/ready output until taken.
module mac_accumulator #(
   parameter int N     = 4,
   parameter int K     = 16,
   parameter int ACC_W = 12,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   mac_accumulator_if.slave bus
);

   typedef enum logic {ACC, HOLD} state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_sum_q, acc_sum_d;
   logic [ACC_W-1:0]   acc_prod_q, acc_prod_d;
   logic               ovf_q, ovf_d;
   logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

   logic [N:0]         sum_in_w;
   logic [2*N-1:0]     prod_in_w;
   logic [ACC_W-1:0]   sum_ext, prod_ext;
   logic [ACC_W:0]     sum_add, prod_add;
   logic               in_ready;
   logic               out_valid;
   logic               accept;
   logic               xfer;

   assign sum_in_w  = bus.sum_in;
   assign prod_in_w = bus.prod_in;
   assign sum_ext   = ACC_W'(sum_in_w);
   assign prod_ext  = ACC_W'(prod_in_w);

   assign out_valid = (state_q == HOLD);
   assign accept    = bus.in_valid & in_ready;
   assign xfer      = out_valid & bus.out_ready;

   // Beat acceptance: always while collecting, only alongside a transfer while holding
   always_comb begin
      in_ready = 1'b0;
      if (rst_n && !bus.clear) begin
         in_ready = (state_q == ACC) || bus.out_ready;
      end
   end

   // Next-state: frame collection, result hand-off and frame abort
   always_comb begin
      state_d    = state_q;
      acc_sum_d  = acc_sum_q;
      acc_prod_d = acc_prod_q;
      ovf_d      = ovf_q;
      beat_cnt_d = beat_cnt_q;
      sum_add    = {1'b0, acc_sum_q}  + {1'b0, sum_ext};
      prod_add   = {1'b0, acc_prod_q} + {1'b0, prod_ext};

      if (bus.clear) begin
         state_d    = ACC;
         acc_sum_d  = '0;
         acc_prod_d = '0;
         ovf_d      = 1'b0;
         beat_cnt_d = '0;
      end else if (state_q == ACC) begin
         if (accept) begin
            acc_sum_d  = sum_add[ACC_W-1:0];
            acc_prod_d = prod_add[ACC_W-1:0];
            ovf_d      = ovf_q | sum_add[ACC_W] | prod_add[ACC_W];
            if (beat_cnt_q == CNT_W'(K - 1)) begin
               beat_cnt_d = '0;
               state_d    = HOLD;
            end else begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
         end
      end else if (xfer) begin
         ovf_d = 1'b0;
         if (accept) begin
            // The beat taken alongside the transfer opens the next frame
            acc_sum_d  = sum_ext;
            acc_prod_d = prod_ext;
            if (K == 1) begin
               beat_cnt_d = '0;
               state_d    = HOLD;
            end else begin
               beat_cnt_d = CNT_W'(1);
               state_d    = ACC;
            end
         end else begin
            acc_sum_d  = '0;
            acc_prod_d = '0;
            beat_cnt_d = '0;
            state_d    = ACC;
         end
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ACC;
         acc_sum_q  <= '0;
         acc_prod_q <= '0;
         ovf_q      <= 1'b0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         acc_sum_q  <= acc_sum_d;
         acc_prod_q <= acc_prod_d;
         ovf_q      <= ovf_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.acc_sum   = acc_sum_q;
   assign bus.acc_prod  = acc_prod_q;
   assign bus.ovf       = ovf_q;
   assign bus.beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: directed scenarios plus a
// randomized run scored against a frame-level reference model.
module tb_mac_accumulator;
   localparam int N     = 4;
   localparam int K     = 16;
   localparam int ACC_W = 12;
   localparam int CNT_W = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   mac_accumulator_if #(.N(N), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus0 ();
   mac_accumulator #(.N(N), .K(K), .ACC_W(ACC_W), .CNT_W(CNT_W)) u0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0.slave));

   mac_accumulator_if #(.N(4), .ACC_W(8), .CNT_W(2)) bus1 ();
   mac_accumulator #(.N(4), .K(2), .ACC_W(8), .CNT_W(2)) u1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   mac_accumulator_if #(.N(4), .ACC_W(12), .CNT_W(1)) bus2 ();
   mac_accumulator #(.N(4), .K(1), .ACC_W(12), .CNT_W(1)) u2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

   // Frame total modulo 2^w; c is set when any addition carries past w bits
   function automatic void frame_total(input int v[$], input int w, output int tot, output bit c);
      tot = 0;
      c   = 1'b0;
      foreach (v[i]) begin
         if (tot + v[i] >= (1 << w)) c = 1'b1;
         tot = (tot + v[i]) % (1 << w);
      end
   endfunction

   task automatic step0(input bit v, input int s, input int p, input bit ordy, input bit clr);
      @(negedge clk);
      bus0.in_valid  = v;
      bus0.sum_in    = (N+1)'(s);
      bus0.prod_in   = (2*N)'(p);
      bus0.out_ready = ordy;
      bus0.clear     = clr;
      #1;
   endtask

   // Feeds one frame with out_ready high and returns the presented result
   task automatic feed0(input int sq[$], input int pq[$], output bit seen,
                        output logic [ACC_W-1:0] gs, output logic [ACC_W-1:0] gp, output logic go);
      seen = 1'b0;
      gs   = 'x;
      gp   = 'x;
      go   = 1'bx;
      foreach (sq[i]) step0(1'b1, sq[i], pq[i], 1'b1, 1'b0);
      for (int c = 0; c < 10; c++) begin
         step0(1'b0, 0, 0, 1'b1, 1'b0);
         if (bus0.out_valid === 1'b1) begin
            seen = 1'b1;
            gs   = bus0.acc_sum;
            gp   = bus0.acc_prod;
            go   = bus0.ovf;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus0.in_valid = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (bus0.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b expected 0", bus0.in_ready);
      end
      n_checks++;
      if ({bus0.out_valid, bus0.ovf, bus0.acc_sum, bus0.acc_prod, bus0.beat_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%b ovf=%b sum=%h prod=%h cnt=%0d expected all zero",
                  bus0.out_valid, bus0.ovf, bus0.acc_sum, bus0.acc_prod, bus0.beat_cnt);
      end
      n_checks++;
      if ({bus1.out_valid, bus1.acc_prod, bus2.out_valid, bus2.acc_prod} !== '0) begin
         n_fail++;
         $display("FAIL reset_small_duts: v1=%b p1=%h v2=%b p2=%h expected zero",
                  bus1.out_valid, bus1.acc_prod, bus2.out_valid, bus2.acc_prod);
      end
      bus0.in_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_ramp();
      int sq[$];
      int pq[$];
      int es, ep, first, xfer, pulses, accepts;
      bit os, op;
      logic [ACC_W-1:0] gs, gp;
      logic go;
      first = -1; xfer = -1; pulses = 0; accepts = 0;
      gs = 'x; gp = 'x; go = 1'bx;
      for (int i = 0; i < K; i++) begin
         sq.push_back(2 * i);
         pq.push_back(i * i);
      end
      frame_total(sq, ACC_W, es, os);
      frame_total(pq, ACC_W, ep, op);
      for (int c = 0; c < 24; c++) begin
         if (c < K) step0(1'b1, 2 * c, c * c, 1'b1, 1'b0);
         else       step0(1'b0, 0, 0, 1'b1, 1'b0);
         if (bus0.in_valid && bus0.in_ready === 1'b1) begin
            accepts++;
            if (first < 0) first = c;
         end
         if (bus0.out_valid === 1'b1) begin
            pulses++;
            if (xfer < 0) begin
               xfer = c;
               gs = bus0.acc_sum;
               gp = bus0.acc_prod;
               go = bus0.ovf;
            end
         end
      end
      n_checks++;
      if (accepts != K) begin n_fail++; $display("FAIL ramp_accepts: got %0d expected %0d", accepts, K); end
      n_checks++;
      if (pulses != 1) begin n_fail++; $display("FAIL ramp_pulses: got %0d expected 1", pulses); end
      n_checks++;
      if (xfer - first + 1 != 17) begin
         n_fail++;
         $display("FAIL ramp_latency: got %0d cycles expected 17", xfer - first + 1);
      end
      n_checks++;
      if ({gs, gp, go} !== {ACC_W'(es), ACC_W'(ep), os | op}) begin
         n_fail++;
         $display("FAIL ramp_result: got sum=%h prod=%h ovf=%b expected sum=%h prod=%h ovf=%b",
                  gs, gp, go, ACC_W'(es), ACC_W'(ep), os | op);
      end
   endtask

   task automatic test_max();
      int sq[$];
      int pq[$];
      int es, ep;
      bit os, op, seen;
      logic [ACC_W-1:0] gs, gp;
      logic go;
      for (int i = 0; i < K; i++) begin
         sq.push_back(30);
         pq.push_back(225);
      end
      frame_total(sq, ACC_W, es, os);
      frame_total(pq, ACC_W, ep, op);
      feed0(sq, pq, seen, gs, gp, go);
      n_checks++;
      if (!seen || {gs, gp, go} !== {ACC_W'(es), ACC_W'(ep), os | op}) begin
         n_fail++;
         $display("FAIL max_result: seen=%b sum=%h prod=%h ovf=%b expected sum=%h prod=%h ovf=%b",
                  seen, gs, gp, go, ACC_W'(es), ACC_W'(ep), os | op);
      end
   endtask

   task automatic test_hold();
      int sq[$];
      int pq[$];
      int es, ep, x, y, bs, bp;
      bit os, op;
      for (int i = 0; i < K; i++) begin
         x = $urandom_range(0, 15);
         y = $urandom_range(0, 15);
         sq.push_back(x + y + $urandom_range(0, 1));
         pq.push_back(x * y);
      end
      frame_total(sq, ACC_W, es, os);
      frame_total(pq, ACC_W, ep, op);
      foreach (sq[i]) step0(1'b1, sq[i], pq[i], 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         step0(1'b1, $urandom_range(0, 31), $urandom_range(0, 225), 1'b0, 1'b0);
         n_checks++;
         if ({bus0.out_valid, bus0.in_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_handshake: cycle %0d valid=%b ready=%b expected valid=1 ready=0",
                     c, bus0.out_valid, bus0.in_ready);
         end
         n_checks++;
         if ({bus0.acc_sum, bus0.acc_prod, bus0.ovf} !== {ACC_W'(es), ACC_W'(ep), os | op}) begin
            n_fail++;
            $display("FAIL hold_stable: cycle %0d sum=%h prod=%h ovf=%b expected sum=%h prod=%h ovf=%b",
                     c, bus0.acc_sum, bus0.acc_prod, bus0.ovf, ACC_W'(es), ACC_W'(ep), os | op);
         end
      end
      x  = $urandom_range(0, 15);
      y  = $urandom_range(0, 15);
      bs = x + y;
      bp = x * y;
      step0(1'b1, bs, bp, 1'b1, 1'b0);
      n_checks++;
      if ({bus0.out_valid, bus0.in_ready} !== 2'b11) begin
         n_fail++;
         $display("FAIL hold_release: valid=%b ready=%b expected 1 1", bus0.out_valid, bus0.in_ready);
      end
      step0(1'b0, 0, 0, 1'b0, 1'b0);
      n_checks++;
      if ({bus0.out_valid, bus0.beat_cnt, bus0.acc_sum, bus0.acc_prod, bus0.ovf} !==
          {1'b0, CNT_W'(1), ACC_W'(bs), ACC_W'(bp), 1'b0}) begin
         n_fail++;
         $display("FAIL hold_next_frame: valid=%b cnt=%0d sum=%h prod=%h ovf=%b expected 0 1 %h %h 0",
                  bus0.out_valid, bus0.beat_cnt, bus0.acc_sum, bus0.acc_prod, bus0.ovf,
                  ACC_W'(bs), ACC_W'(bp));
      end
      step0(1'b0, 0, 0, 1'b0, 1'b1);
   endtask

   task automatic test_abort();
      int sq[$];
      int pq[$];
      int es, ep, x, y;
      bit os, op, seen;
      logic [ACC_W-1:0] gs, gp;
      logic go;
      // Part A: asynchronous reset after 7 beats
      for (int i = 0; i < 7; i++) begin
         x = $urandom_range(0, 15);
         y = $urandom_range(0, 15);
         sq.push_back(x + y);
         pq.push_back(x * y);
      end
      frame_total(sq, ACC_W, es, os);
      frame_total(pq, ACC_W, ep, op);
      foreach (sq[i]) step0(1'b1, sq[i], pq[i], 1'b1, 1'b0);
      step0(1'b0, 0, 0, 1'b1, 1'b0);
      n_checks++;
      if ({bus0.beat_cnt, bus0.acc_sum, bus0.acc_prod} !== {CNT_W'(7), ACC_W'(es), ACC_W'(ep)}) begin
         n_fail++;
         $display("FAIL abort_partial: cnt=%0d sum=%h prod=%h expected 7 %h %h",
                  bus0.beat_cnt, bus0.acc_sum, bus0.acc_prod, ACC_W'(es), ACC_W'(ep));
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus0.out_valid, bus0.in_ready, bus0.ovf, bus0.beat_cnt, bus0.acc_sum, bus0.acc_prod} !== '0) begin
         n_fail++;
         $display("FAIL abort_reset: valid=%b ready=%b ovf=%b cnt=%0d sum=%h prod=%h expected all zero",
                  bus0.out_valid, bus0.in_ready, bus0.ovf, bus0.beat_cnt, bus0.acc_sum, bus0.acc_prod);
      end
      @(negedge clk);
      rst_n = 1'b1;
      // Part B: synchronous clear after 7 beats, clear-cycle beat offered
      foreach (sq[i]) step0(1'b1, sq[i], pq[i], 1'b1, 1'b0);
      step0(1'b1, 31, 225, 1'b1, 1'b1);
      n_checks++;
      if ({bus0.in_ready, bus0.beat_cnt} !== {1'b0, CNT_W'(7)}) begin
         n_fail++;
         $display("FAIL abort_clear_cycle: ready=%b cnt=%0d expected 0 7", bus0.in_ready, bus0.beat_cnt);
      end
      step0(1'b0, 0, 0, 1'b1, 1'b0);
      n_checks++;
      if ({bus0.out_valid, bus0.ovf, bus0.beat_cnt, bus0.acc_sum, bus0.acc_prod} !== '0) begin
         n_fail++;
         $display("FAIL abort_cleared: valid=%b ovf=%b cnt=%0d sum=%h prod=%h expected all zero",
                  bus0.out_valid, bus0.ovf, bus0.beat_cnt, bus0.acc_sum, bus0.acc_prod);
      end
      sq.delete();
      pq.delete();
      for (int i = 0; i < K; i++) begin
         x = $urandom_range(0, 15);
         y = $urandom_range(0, 15);
         sq.push_back(x + y + $urandom_range(0, 1));
         pq.push_back(x * y);
      end
      frame_total(sq, ACC_W, es, os);
      frame_total(pq, ACC_W, ep, op);
      feed0(sq, pq, seen, gs, gp, go);
      n_checks++;
      if (!seen || {gs, gp, go} !== {ACC_W'(es), ACC_W'(ep), os | op}) begin
         n_fail++;
         $display("FAIL abort_following_frame: seen=%b sum=%h prod=%h ovf=%b expected %h %h %b",
                  seen, gs, gp, go, ACC_W'(es), ACC_W'(ep), os | op);
      end
   endtask

   task automatic test_ovf();
      int sq[$] = '{30, 30};
      int pq[$] = '{225, 225};
      int nq[$] = '{1, 1};
      int es, ep, e2;
      bit os, op, o2;
      frame_total(sq, 8, es, os);
      frame_total(pq, 8, ep, op);
      frame_total(nq, 8, e2, o2);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         bus1.in_valid  = (c < 4);
         bus1.sum_in    = (c < 2) ? 5'd30 : 5'd2;
         bus1.prod_in   = (c < 2) ? 8'd225 : 8'd1;
         bus1.out_ready = 1'b1;
         bus1.clear     = 1'b0;
         #1;
         if (c == 2) begin
            n_checks++;
            if ({bus1.out_valid, bus1.in_ready, bus1.acc_sum, bus1.acc_prod, bus1.ovf} !==
                {2'b11, 8'(es), 8'(ep), os | op}) begin
               n_fail++;
               $display("FAIL ovf_frame: valid=%b ready=%b sum=%h prod=%h ovf=%b expected 1 1 %h %h %b",
                        bus1.out_valid, bus1.in_ready, bus1.acc_sum, bus1.acc_prod, bus1.ovf,
                        8'(es), 8'(ep), os | op);
            end
         end else if (c == 3) begin
            n_checks++;
            if ({bus1.out_valid, bus1.ovf, bus1.beat_cnt} !== {2'b00, 2'd1}) begin
               n_fail++;
               $display("FAIL ovf_restart: valid=%b ovf=%b cnt=%0d expected 0 0 1",
                        bus1.out_valid, bus1.ovf, bus1.beat_cnt);
            end
         end else if (c == 4) begin
            n_checks++;
            if ({bus1.out_valid, bus1.acc_prod, bus1.ovf} !== {1'b1, 8'(e2), o2}) begin
               n_fail++;
               $display("FAIL ovf_next_frame: valid=%b prod=%h ovf=%b expected 1 %h %b",
                        bus1.out_valid, bus1.acc_prod, bus1.ovf, 8'(e2), o2);
            end
         end
      end
      bus1.in_valid  = 1'b0;
      bus1.out_ready = 1'b0;
   endtask

   task automatic test_k1();
      int sv[$];
      int pv[$];
      int x, y, es, ep;
      bit os, op;
      for (int c = 0; c < 12; c++) begin
         x = $urandom_range(0, 15);
         y = $urandom_range(0, 15);
         @(negedge clk);
         bus2.in_valid  = 1'b1;
         bus2.sum_in    = 5'(x + y);
         bus2.prod_in   = 8'(x * y);
         bus2.out_ready = 1'b1;
         bus2.clear     = 1'b0;
         #1;
         if (c == 0) begin
            n_checks++;
            if (bus2.out_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL k1_first: valid=%b expected 0", bus2.out_valid);
            end
         end else begin
            frame_total(sv[c-1:c-1], 12, es, os);
            frame_total(pv[c-1:c-1], 12, ep, op);
            n_checks++;
            if ({bus2.out_valid, bus2.acc_sum, bus2.acc_prod, bus2.ovf} !==
                {1'b1, 12'(es), 12'(ep), os | op}) begin
               n_fail++;
               $display("FAIL k1_track: cycle %0d valid=%b sum=%h prod=%h ovf=%b expected 1 %h %h %b",
                        c, bus2.out_valid, bus2.acc_sum, bus2.acc_prod, bus2.ovf, 12'(es), 12'(ep), os | op);
            end
         end
         sv.push_back(x + y);
         pv.push_back(x * y);
      end
      @(negedge clk);
      bus2.in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      int sf[$];
      int pf[$];
      int res_s, res_p, exp_s, exp_p, exp_cnt, x, y, s, p;
      bit pending, res_o, exp_o, exp_ready, exp_valid, v, ordy, clr, o1, o2;
      logic [1+1+CNT_W+2*ACC_W-1:0] expv, gotv;
      pending = 1'b0;
      res_s = 0; res_p = 0; res_o = 1'b0;
      for (int c = 0; c < 600; c++) begin
         v    = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         clr  = ($urandom_range(0, 39) == 0);
         x    = $urandom_range(0, 15);
         y    = $urandom_range(0, 15);
         s    = x + y + $urandom_range(0, 1);
         p    = x * y;
         step0(v, s, p, ordy, clr);
         exp_ready = !clr && (!pending || ordy);
         n_checks++;
         if (bus0.in_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL rand_in_ready: cycle %0d got %b expected %b", c, bus0.in_ready, exp_ready);
         end
         if (pending) begin
            exp_valid = 1'b1; exp_s = res_s; exp_p = res_p; exp_o = res_o; exp_cnt = 0;
         end else begin
            exp_valid = 1'b0;
            frame_total(sf, ACC_W, exp_s, o1);
            frame_total(pf, ACC_W, exp_p, o2);
            exp_o   = o1 | o2;
            exp_cnt = sf.size();
         end
         expv = {exp_valid, exp_o, CNT_W'(exp_cnt), ACC_W'(exp_s), ACC_W'(exp_p)};
         gotv = {bus0.out_valid, bus0.ovf, bus0.beat_cnt, bus0.acc_sum, bus0.acc_prod};
         n_checks++;
         if (gotv !== expv) begin
            n_fail++;
            $display("FAIL rand_outputs: cycle %0d got valid=%b ovf=%b cnt=%0d sum=%h prod=%h expected valid=%b ovf=%b cnt=%0d sum=%h prod=%h",
                     c, bus0.out_valid, bus0.ovf, bus0.beat_cnt, bus0.acc_sum, bus0.acc_prod,
                     exp_valid, exp_o, exp_cnt, ACC_W'(exp_s), ACC_W'(exp_p));
         end
         if (clr) begin
            sf.delete();
            pf.delete();
            pending = 1'b0;
         end else begin
            if (pending && ordy) pending = 1'b0;
            if (v && exp_ready) begin
               sf.push_back(s);
               pf.push_back(p);
               if (sf.size() == K) begin
                  frame_total(sf, ACC_W, res_s, o1);
                  frame_total(pf, ACC_W, res_p, o2);
                  res_o   = o1 | o2;
                  pending = 1'b1;
                  sf.delete();
                  pf.delete();
               end
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus0.in_valid = 1'b0; bus0.out_ready = 1'b0; bus0.clear = 1'b0; bus0.sum_in = '0; bus0.prod_in = '0;
      bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.clear = 1'b0; bus1.sum_in = '0; bus1.prod_in = '0;
      bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.clear = 1'b0; bus2.sum_in = '0; bus2.prod_in = '0;
      test_reset();
      test_ramp();
      test_max();
      test_hold();
      test_abort();
      test_ovf();
      test_k1();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
